// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 fetch arbiter: request source tag and arbiter state.
package l2_arb_pkg;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/l2_arb_tag_fifo.sv
// In-order 1-bit source-tag FIFO; push and pop may occur together, head is read before the push.
module l2_arb_tag_fifo
  import l2_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  src_e push_src_i,
  input  logic pop_i,
  output src_e head_o,
  output logic empty_o,
  output logic full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign head_o  = src_e'(mem_q[rd_ptr_q]);

  // A pop frees the slot the simultaneous push may need when full.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_src_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/l2_fetch_arbiter.sv
// Arbitrates I/D miss requests onto the single L2 read-address channel and routes responses back.
// Define L2_ARB_DCACHE_PRIORITY_EN to make D win every contended cycle instead of round-robin.
module l2_fetch_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ_I_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ_I_ADDR,
  output logic                  REQ_I_READY,
  input  logic                  REQ_D_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ_D_ADDR,
  output logic                  REQ_D_READY,
  output logic                  L2_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0] L2_ADDR,
  input  logic                  L2_ADDR_READY,
  input  logic                  L2_RESP_VALID,
  output logic                  RESP_I_VALID,
  output logic                  RESP_D_VALID,
  output logic [CNT_WIDTH-1:0]  OUTSTANDING,
  output logic                  ORDER_ERR
);

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  order_err_q, order_err_d;

  logic can_accept, grant_i, grant_d, accept, resp_pop;
  src_e win_src, fifo_head;
  logic fifo_empty, fifo_full;

  // FIFO occupancy tracks the counter exactly, so its flags stand in for count compares.
  assign can_accept = ((state_q == IDLE) | L2_ADDR_READY) & (~fifo_full | L2_RESP_VALID);

`ifdef L2_ARB_DCACHE_PRIORITY_EN
  assign grant_d = REQ_D_VALID;
`else
  src_e rr_q, rr_d;

  assign grant_d = REQ_D_VALID & (~REQ_I_VALID | (rr_q == SRC_D));

  // Pointer only moves on a contended accept, to the source that lost.
  always_comb begin
    rr_d = rr_q;
    if (accept && REQ_I_VALID && REQ_D_VALID) begin
      rr_d = (win_src == SRC_D) ? SRC_I : SRC_D;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rr_q <= SRC_I;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign grant_i  = REQ_I_VALID & ~grant_d;
  assign accept   = can_accept & (grant_i | grant_d);
  assign win_src  = grant_d ? SRC_D : SRC_I;
  assign resp_pop = L2_RESP_VALID & ~fifo_empty;

  assign REQ_I_READY   = can_accept & grant_i;
  assign REQ_D_READY   = can_accept & grant_d;
  assign L2_ADDR_VALID = (state_q == HOLD);
  assign L2_ADDR       = addr_q;
  assign RESP_I_VALID  = resp_pop & (fifo_head == SRC_I);
  assign RESP_D_VALID  = resp_pop & (fifo_head == SRC_D);
  assign OUTSTANDING   = cnt_q;
  assign ORDER_ERR     = order_err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    order_err_d = order_err_q | (L2_RESP_VALID & fifo_empty);
    if (accept) begin
      state_d = HOLD;
      addr_d  = grant_d ? REQ_D_ADDR : REQ_I_ADDR;
    end else if ((state_q == HOLD) && L2_ADDR_READY) begin
      state_d = IDLE;
    end
    unique case ({accept, resp_pop})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      order_err_q <= order_err_d;
    end
  end

  l2_arb_tag_fifo #(
    .Depth(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i     (CLK),
    .rst_ni    (RSTN),
    .push_i    (accept),
    .push_src_i(win_src),
    .pop_i     (resp_pop),
    .head_o    (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

endmodule

// File: tb/tb_l2_fetch_arbiter.sv
// Scoreboard bench for l2_fetch_arbiter: expected L2 addresses and response routes are queued
// at request acceptance and compared when the DUT issues or routes them.
module tb_l2_fetch_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned MaxOut = 4;
  localparam int unsigned CW = $clog2(MaxOut + 1);

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          REQ_I_VALID = 1'b0;
  logic [AW-1:0] REQ_I_ADDR = '0;
  logic          REQ_I_READY;
  logic          REQ_D_VALID = 1'b0;
  logic [AW-1:0] REQ_D_ADDR = '0;
  logic          REQ_D_READY;
  logic          L2_ADDR_VALID;
  logic [AW-1:0] L2_ADDR;
  logic          L2_ADDR_READY = 1'b0;
  logic          L2_RESP_VALID = 1'b0;
  logic          RESP_I_VALID;
  logic          RESP_D_VALID;
  logic [CW-1:0] OUTSTANDING;
  logic          ORDER_ERR;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr_q[$];
  bit          exp_src_q[$];

  always #5 CLK = ~CLK;

  l2_fetch_arbiter #(
    .ADDR_WIDTH     (AW),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .REQ_I_VALID  (REQ_I_VALID),
    .REQ_I_ADDR   (REQ_I_ADDR),
    .REQ_I_READY  (REQ_I_READY),
    .REQ_D_VALID  (REQ_D_VALID),
    .REQ_D_ADDR   (REQ_D_ADDR),
    .REQ_D_READY  (REQ_D_READY),
    .L2_ADDR_VALID(L2_ADDR_VALID),
    .L2_ADDR      (L2_ADDR),
    .L2_ADDR_READY(L2_ADDR_READY),
    .L2_RESP_VALID(L2_RESP_VALID),
    .RESP_I_VALID (RESP_I_VALID),
    .RESP_D_VALID (RESP_D_VALID),
    .OUTSTANDING  (OUTSTANDING),
    .ORDER_ERR    (ORDER_ERR)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: address handshakes and response pulses, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (L2_ADDR_VALID && L2_ADDR_READY) begin
        if (exp_addr_q.size() == 0) check_eq("issue_unexpected", 1, 0);
        else check_eq("l2_addr", L2_ADDR, exp_addr_q.pop_front());
      end
      if (L2_RESP_VALID) begin
        if (exp_src_q.size() == 0) begin
          check_eq("resp_i_spurious", RESP_I_VALID, 0);
          check_eq("resp_d_spurious", RESP_D_VALID, 0);
        end else begin
          bit s;
          s = exp_src_q.pop_front();
          check_eq("resp_i_route", RESP_I_VALID, !s);
          check_eq("resp_d_route", RESP_D_VALID, s);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_req(input bit src, input logic [31:0] addr);
    bit done;
    done = 1'b0;
    if (src) begin
      REQ_D_VALID = 1'b1;
      REQ_D_ADDR  = addr;
    end else begin
      REQ_I_VALID = 1'b1;
      REQ_I_ADDR  = addr;
    end
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge CLK);
      if (src ? REQ_D_READY : REQ_I_READY) begin
        exp_addr_q.push_back(addr);
        exp_src_q.push_back(src);
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    REQ_I_VALID = 1'b0;
    REQ_D_VALID = 1'b0;
    if (!done) check_eq("req_timeout", 0, 1);
  endtask

  task automatic resp_pulse();
    L2_RESP_VALID = 1'b1;
    @(posedge CLK);
    #1;
    L2_RESP_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    exp_addr_q.delete();
    exp_src_q.delete();
  endtask

  initial begin
    int k;
    int cyc;
    bit exp_d;

    do_reset();
    check_eq("rst_valid", L2_ADDR_VALID, 0);
    check_eq("rst_addr", L2_ADDR, 0);
    check_eq("rst_outstanding", OUTSTANDING, 0);
    check_eq("rst_order_err", ORDER_ERR, 0);
    check_eq("rst_ready_i", REQ_I_READY, 0);

    // Single request, one-cycle issue latency.
    L2_ADDR_READY = 1'b1;
    drive_req(1'b0, 32'h1000);
    check_eq("single_valid", L2_ADDR_VALID, 1);
    check_eq("single_addr", L2_ADDR, 32'h1000);
    check_eq("single_outst", OUTSTANDING, 1);
    @(posedge CLK);
    #1;
    check_eq("single_valid_drop", L2_ADDR_VALID, 0);
    resp_pulse();
    check_eq("single_outst_0", OUTSTANDING, 0);

    // Contention from a fresh round-robin pointer.
    do_reset();
    L2_ADDR_READY = 1'b1;
    REQ_I_VALID = 1'b1;
    REQ_D_VALID = 1'b1;
    REQ_I_ADDR  = 32'h2000;
    REQ_D_ADDR  = 32'h3000;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (REQ_I_READY || REQ_D_READY) begin
`ifdef L2_ARB_DCACHE_PRIORITY_EN
        exp_d = 1'b1;
`else
        exp_d = (k % 2) == 1;
`endif
        check_eq("contend_ready_d", REQ_D_READY, exp_d);
        check_eq("contend_ready_i", REQ_I_READY, !exp_d);
        exp_addr_q.push_back(exp_d ? REQ_D_ADDR : REQ_I_ADDR);
        exp_src_q.push_back(exp_d);
        k++;
        @(posedge CLK);
        #1;
        REQ_I_ADDR = 32'h2000 + 32'(k * 4);
        REQ_D_ADDR = 32'h3000 + 32'(k * 4);
      end
    end
    REQ_I_VALID = 1'b0;
    REQ_D_VALID = 1'b0;
    if (k < 4) check_eq("contend_timeout", k, 4);
    check_eq("contend_outst", OUTSTANDING, 4);
    repeat (4) resp_pulse();
    check_eq("contend_drained", OUTSTANDING, 0);

    // Backpressure: address held, no second accept, then back-to-back issue.
    L2_ADDR_READY = 1'b0;
    drive_req(1'b1, 32'h4000);
    REQ_I_VALID = 1'b1;
    REQ_I_ADDR  = 32'h4100;
    repeat (5) begin
      @(negedge CLK);
      check_eq("bp_valid", L2_ADDR_VALID, 1);
      check_eq("bp_addr", L2_ADDR, 32'h4000);
      check_eq("bp_ready_i", REQ_I_READY, 0);
      check_eq("bp_outst", OUTSTANDING, 1);
    end
    @(posedge CLK);
    #1;
    L2_ADDR_READY = 1'b1;
    @(negedge CLK);
    check_eq("bp_release_ready_i", REQ_I_READY, 1);
    exp_addr_q.push_back(32'h4100);
    exp_src_q.push_back(1'b0);
    @(posedge CLK);
    #1;
    REQ_I_VALID = 1'b0;
    check_eq("b2b_valid", L2_ADDR_VALID, 1);
    check_eq("b2b_addr", L2_ADDR, 32'h4100);
    repeat (2) resp_pulse();
    check_eq("bp_drained", OUTSTANDING, 0);

    // Full, then a response frees a slot in the same cycle as a new accept.
    drive_req(1'b0, 32'h5000);
    drive_req(1'b1, 32'h5004);
    drive_req(1'b1, 32'h5008);
    drive_req(1'b0, 32'h500C);
    check_eq("full_outst", OUTSTANDING, 4);
    REQ_I_VALID = 1'b1;
    REQ_I_ADDR  = 32'h5010;
    repeat (2) begin
      @(negedge CLK);
      check_eq("full_ready_i", REQ_I_READY, 0);
    end
    @(posedge CLK);
    #1;
    L2_RESP_VALID = 1'b1;
    @(negedge CLK);
    check_eq("full_resp_ready_i", REQ_I_READY, 1);
    exp_addr_q.push_back(32'h5010);
    exp_src_q.push_back(1'b0);
    @(posedge CLK);
    #1;
    L2_RESP_VALID = 1'b0;
    REQ_I_VALID = 1'b0;
    check_eq("full_outst_hold", OUTSTANDING, 4);
    repeat (4) resp_pulse();
    check_eq("full_drained", OUTSTANDING, 0);

    // Ordering I,D,D,I then an extra response.
    drive_req(1'b0, 32'h6000);
    drive_req(1'b1, 32'h6004);
    drive_req(1'b1, 32'h6008);
    drive_req(1'b0, 32'h600C);
    repeat (4) resp_pulse();
    check_eq("order_err_clean", ORDER_ERR, 0);
    resp_pulse();
    check_eq("order_err_set", ORDER_ERR, 1);
    check_eq("order_no_underflow", OUTSTANDING, 0);
    @(posedge CLK);
    #1;
    check_eq("order_err_sticky", ORDER_ERR, 1);

    // Asynchronous reset in the middle of HOLD.
    L2_ADDR_READY = 1'b0;
    drive_req(1'b0, 32'h7000);
    #2;
    RSTN = 1'b0;
    #1;
    check_eq("arst_valid", L2_ADDR_VALID, 0);
    check_eq("arst_addr", L2_ADDR, 0);
    check_eq("arst_outst", OUTSTANDING, 0);
    check_eq("arst_order_err", ORDER_ERR, 0);
    exp_addr_q.delete();
    exp_src_q.delete();
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    L2_ADDR_READY = 1'b1;
    resp_pulse();
    check_eq("arst_stale_resp_err", ORDER_ERR, 1);
    check_eq("arst_stale_outst", OUTSTANDING, 0);

    check_eq("sb_addr_left", exp_addr_q.size(), 0);
    check_eq("sb_src_left", exp_src_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l2_fetch_arbiter.md
Name: l2_fetch_arbiter

Overview:
- Shares the single L2 read-address channel between two miss sources: the instruction-cache fetch queue (I) and the data-cache miss path (D).
- Registers the winning address, holds it until L2 accepts it, and caps the number of in-flight requests.
- Records the source of every issued request in an in-order tag FIFO, so each L2 response pulse is routed back to the requester that issued it.
- Sits between the per-cache fetch queues and the L2 cache request port.

Parameters:
- ADDR_WIDTH, 32, width of request address.
- MAX_OUTSTANDING, 4, maximum requests accepted but not yet responded to; power of two, 2..16.
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived).

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- REQ_I_VALID  in  1  I-side request present.
- REQ_I_ADDR  in  ADDR_WIDTH  I-side address.
- REQ_I_READY  out  1  I-side request accepted this cycle when VALID is also high.
- REQ_D_VALID  in  1  D-side request present.
- REQ_D_ADDR  in  ADDR_WIDTH  D-side address.
- REQ_D_READY  out  1  D-side accept.
- L2_ADDR_VALID  out  1  registered address valid to L2.
- L2_ADDR  out  ADDR_WIDTH  registered address to L2.
- L2_ADDR_READY  in  1  L2 takes the address.
- L2_RESP_VALID  in  1  one-cycle pulse per completed request; L2 returns responses in order.
- RESP_I_VALID  out  1  routed response pulse for I.
- RESP_D_VALID  out  1  routed response pulse for D.
- OUTSTANDING  out  CNT_WIDTH  current in-flight count.
- ORDER_ERR  out  1  sticky: a response arrived with no request outstanding.

Behaviour:
- Reset (async assert, synchronous-safe deassert): L2_ADDR_VALID=0, L2_ADDR=0, OUTSTANDING=0, ORDER_ERR=0, tag FIFO empty, round-robin pointer = I, state=IDLE.
- States:
  - IDLE: no address held.
  - HOLD: L2_ADDR_VALID=1, waiting for L2_ADDR_READY.
- can_accept = (state==IDLE | L2_ADDR_READY) & (OUTSTANDING<MAX_OUTSTANDING | L2_RESP_VALID). A response in the same cycle frees a slot.
- Grant (combinational), only when can_accept:
  - One valid requester: it wins.
  - Both valid: the winner is the round-robin pointer; the pointer then moves to the other source.
  - REQ_x_READY = can_accept & grant_x. At most one READY is high per cycle.
- Accept in cycle N:
  - L2_ADDR <= winner address; L2_ADDR_VALID=1 from cycle N+1. Latency is 1 cycle.
  - Push the source tag to the FIFO.
  - OUTSTANDING += 1.
- HOLD: L2_ADDR and L2_ADDR_VALID are stable until L2_ADDR_READY.
  - On READY with a new accept in the same cycle: stay in HOLD with the new address, giving back-to-back issue.
  - On READY without an accept: go to IDLE, L2_ADDR_VALID=0.
- Response:
  - RESP_I_VALID = L2_RESP_VALID & head==I; RESP_D_VALID = L2_RESP_VALID & head==D. Both are combinational.
  - Pop the FIFO; OUTSTANDING -= 1.
- Accept and response in the same cycle: push and pop together, OUTSTANDING unchanged. The FIFO head is read before the push.
- Response with OUTSTANDING==0:
  - No RESP_x pulse, no pop, the counter does not underflow.
  - ORDER_ERR is set and stays set until reset.
- Full (OUTSTANDING==MAX and no response this cycle): both READYs are 0. A held address still completes.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Count and FIFO occupancy are always equal.
- Reset mid-operation discards held address and tags. Responses arriving after reset for discarded requests set ORDER_ERR.

Optional Feature:
- Macro: L2_ARB_DCACHE_PRIORITY_EN.
- Defined: D always wins when both sources are valid; the round-robin pointer is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package l2_arb_pkg:
  - Source-tag typedef (SRC_I=1'b0, SRC_D=1'b1).
  - Arbiter state enum (IDLE, HOLD).
- One sub-module, l2_arb_tag_fifo: a MAX_OUTSTANDING-deep, 1-bit-wide, synchronous FIFO with push/pop, simultaneous push+pop, head output and empty/full flags.
- Arbitration and the HOLD register stay in the top module.

Test Plan:
- Single request: REQ_I_VALID, ADDR=0x1000, L2_ADDR_READY=1 -> L2_ADDR_VALID with 0x1000 one cycle later for one cycle; L2_RESP_VALID pulse -> RESP_I_VALID=1, OUTSTANDING 1->0.
- Contention: I and D both valid continuously, L2 always ready (no macro) -> issued sources alternate I,D,I,D. With macro -> D,D,D until D drops.
- Backpressure: L2_ADDR_READY=0 for 5 cycles -> L2_ADDR held constant, both READYs 0 while in HOLD, no second push.
- Full: MAX_OUTSTANDING=4 accepts with no responses -> READYs 0. A response in the same cycle as a new request -> request accepted and OUTSTANDING stays 4.
- Ordering: issue I,D,D,I, then 4 response pulses -> routed I,D,D,I exactly. A fifth pulse -> no RESP pulse, ORDER_ERR=1.
- Async reset: assert RSTN=0 mid-HOLD between clock edges -> L2_ADDR_VALID=0 and OUTSTANDING=0 immediately, FIFO empty after release.
